// File: rtl/comparator_4bit_pkg.sv
// Shared types and limits for the registered magnitude comparator.
// Result flags are packed {gt, eq, lt} so one bundle moves through the stage.
package comparator_4bit_pkg;

    localparam int CMP_MAX_WIDTH = 32;

    typedef struct packed {
        logic gt;
        logic eq;
        logic lt;
    } cmp_result_t;

    function automatic cmp_result_t cmp_pack(input logic gt, input logic eq);
        cmp_result_t r;
        r.gt = gt;
        r.eq = eq;
        r.lt = ~gt & ~eq;
        return r;
    endfunction

endpackage

// File: rtl/comparator_4bit_cell.sv
// One bit slice of the MSB-first compare cascade.
// Upstream g/e summarise all more-significant bits.
module cmp_cell (
    input  logic a_bit,
    input  logic b_bit,
    input  logic g_in,
    input  logic e_in,
    output logic g_out,
    output logic e_out
);

    logic g_loc;
    logic e_loc;

    assign g_loc = a_bit & ~b_bit;
    assign e_loc = ~(a_bit ^ b_bit);

    // A lower bit only decides when everything above it was equal.
    assign g_out = g_in | (e_in & g_loc);
    assign e_out = e_in & e_loc;

endmodule

// File: rtl/comparator_4bit.sv
// Registered compare of a against b; result one clock after in_valid.
// Signed mode flips the sign bits so the unsigned cascade orders correctly.
module comparator_4bit
    import comparator_4bit_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic             out_valid
);

    if (WIDTH < 1 || WIDTH > CMP_MAX_WIDTH) begin : g_bad_width
        $error("comparator_4bit: WIDTH out of range");
    end

    logic [WIDTH-1:0] a_adj;
    logic [WIDTH-1:0] b_adj;
    logic [WIDTH:0]   g_chain;
    logic [WIDTH:0]   e_chain;
    cmp_result_t      res_d;
    cmp_result_t      res_q;
    logic             valid_q;

    always_comb begin
        a_adj = a;
        b_adj = b;
        if (SIGNED) begin
            a_adj[WIDTH-1] = ~a[WIDTH-1];
            b_adj[WIDTH-1] = ~b[WIDTH-1];
        end
    end

    // Seed above the MSB: nothing decided yet, all equal so far.
    assign g_chain[WIDTH] = 1'b0;
    assign e_chain[WIDTH] = 1'b1;

    for (genvar i = WIDTH - 1; i >= 0; i--) begin : g_cell
        cmp_cell u_cell (
            .a_bit (a_adj[i]),
            .b_bit (b_adj[i]),
            .g_in  (g_chain[i+1]),
            .e_in  (e_chain[i+1]),
            .g_out (g_chain[i]),
            .e_out (e_chain[i])
        );
    end

    assign res_d = cmp_pack(g_chain[0], e_chain[0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                res_q <= res_d;
            end
        end
    end

    assign gt        = res_q.gt;
    assign eq        = res_q.eq;
    assign lt        = res_q.lt;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_comparator_4bit.sv
// Scoreboarded bench for comparator_4bit, unsigned and signed instances.
module tb_comparator_4bit;
    import comparator_4bit_pkg::*;

    localparam cmp_result_t GT = 3'b100;
    localparam cmp_result_t EQ = 3'b010;
    localparam cmp_result_t LT = 3'b001;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       iv_u  = 1'b0;
    logic       iv_s  = 1'b0;
    logic [3:0] a_u   = '0;
    logic [3:0] b_u   = '0;
    logic [3:0] a_s   = '0;
    logic [3:0] b_s   = '0;
    logic       gt_u, eq_u, lt_u, ov_u;
    logic       gt_s, eq_s, lt_s, ov_s;

    int total = 0;
    int bad   = 0;

    cmp_result_t q_u[$];
    cmp_result_t q_s[$];

    always #5 clk = ~clk;

    comparator_4bit #(.WIDTH(4), .SIGNED(1'b0)) dut_u (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv_u),
        .a         (a_u),
        .b         (b_u),
        .gt        (gt_u),
        .eq        (eq_u),
        .lt        (lt_u),
        .out_valid (ov_u)
    );

    comparator_4bit #(.WIDTH(4), .SIGNED(1'b1)) dut_s (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv_s),
        .a         (a_s),
        .b         (b_s),
        .gt        (gt_s),
        .eq        (eq_s),
        .lt        (lt_s),
        .out_valid (ov_s)
    );

    task automatic chk(input string name, input logic [3:0] act,
                       input logic [3:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, req);
        end
    endtask

    // Monitor: pops one expectation per presented result.
    always @(negedge clk) begin
        cmp_result_t got;
        cmp_result_t exp;
        if (rst_n && ov_u) begin
            got = {gt_u, eq_u, lt_u};
            total++;
            if (q_u.size() == 0) begin
                bad++;
                $display("FAIL unsigned_extra: got %b expected none", got);
            end else begin
                exp = q_u.pop_front();
                if (got !== exp) begin
                    bad++;
                    $display("FAIL unsigned_result: got %b expected %b",
                             got, exp);
                end
            end
        end
        if (rst_n && ov_s) begin
            got = {gt_s, eq_s, lt_s};
            total++;
            if (q_s.size() == 0) begin
                bad++;
                $display("FAIL signed_extra: got %b expected none", got);
            end else begin
                exp = q_s.pop_front();
                if (got !== exp) begin
                    bad++;
                    $display("FAIL signed_result: got %b expected %b",
                             got, exp);
                end
            end
        end
    end

    task automatic issue_u(input logic v, input logic [3:0] a,
                           input logic [3:0] b, input cmp_result_t e);
        @(posedge clk);
        #1;
        iv_u = v;
        a_u  = a;
        b_u  = b;
        if (v) q_u.push_back(e);
    endtask

    task automatic issue_s(input logic v, input logic [3:0] a,
                           input logic [3:0] b, input cmp_result_t e);
        @(posedge clk);
        #1;
        iv_s = v;
        a_s  = a;
        b_s  = b;
        if (v) q_s.push_back(e);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && (q_u.size() != 0 || q_s.size() != 0); i++)
            @(negedge clk);
        total++;
        if (q_u.size() != 0 || q_s.size() != 0) begin
            bad++;
            $display("FAIL %s: got %0d results pending expected 0",
                     name, q_u.size() + q_s.size());
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            a_u  = 4'($urandom_range(15));
            b_u  = 4'($urandom_range(15));
            a_s  = 4'($urandom_range(15));
            b_s  = 4'($urandom_range(15));
            iv_u = 1'b1;
            iv_s = 1'b1;
            @(negedge clk);
            chk("reset_u", {gt_u, eq_u, lt_u, ov_u}, 4'b0000);
            chk("reset_s", {gt_s, eq_s, lt_s, ov_s}, 4'b0000);
        end
        iv_u  = 1'b0;
        iv_s  = 1'b0;
        rst_n = 1'b1;

        issue_u(1'b1, 4'd1,  4'd0,  GT);
        issue_u(1'b1, 4'd3,  4'd1,  GT);
        issue_u(1'b1, 4'd7,  4'd2,  GT);
        issue_u(1'b1, 4'd15, 4'd3,  GT);
        issue_u(1'b1, 4'd15, 4'd10, GT);
        issue_u(1'b1, 4'd15, 4'd0,  GT);
        issue_u(1'b1, 4'd1,  4'd4,  LT);
        issue_u(1'b1, 4'd3,  4'd5,  LT);
        issue_u(1'b1, 4'd7,  4'd9,  LT);
        issue_u(1'b1, 4'd1,  4'd11, LT);
        issue_u(1'b1, 4'd3,  4'd9,  LT);
        issue_u(1'b1, 4'd7,  4'd10, LT);
        issue_u(1'b1, 4'd15, 4'd11, GT);
        issue_u(1'b1, 4'd0,  4'd0,  EQ);
        issue_u(1'b1, 4'd5,  4'd5,  EQ);
        issue_u(1'b1, 4'd15, 4'd15, EQ);
        issue_u(1'b1, 4'd9,  4'd2,  GT);
        issue_u(1'b0, 4'd0,  4'd15, GT);
        @(posedge clk);
        #2;
        chk("hold_u", {gt_u, eq_u, lt_u, ov_u}, 4'b1000);
        drain("drain_u");

        issue_s(1'b1, 4'b0111, 4'b1000, GT);
        issue_s(1'b1, 4'b1000, 4'b0111, LT);
        issue_s(1'b1, 4'b1111, 4'b0000, LT);
        issue_s(1'b1, 4'b1111, 4'b1111, EQ);
        issue_s(1'b1, 4'b1111, 4'b0001, LT);
        issue_s(1'b0, 4'b0000, 4'b0000, EQ);
        drain("drain_s");

        @(posedge clk);
        #2;
        chk("pre_rst_u", {gt_u, eq_u, lt_u, ov_u}, 4'b1000);
        chk("pre_rst_s", {gt_s, eq_s, lt_s, ov_s}, 4'b0010);
        rst_n = 1'b0;
        #1;
        chk("async_rst_u", {gt_u, eq_u, lt_u, ov_u}, 4'b0000);
        chk("async_rst_s", {gt_s, eq_s, lt_s, ov_s}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;

        issue_u(1'b1, 4'd2, 4'd6, LT);
        issue_u(1'b0, 4'd0, 4'd0, EQ);
        drain("drain_post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
